// File: rtl/jtag_wb_master.sv
// Wishbone pipelined initiator for the LM32 debug register port.
// Turns one host command (write / read / write-then-read) into bus transfers and returns one response.
module jtag_wb_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [2:0]  cmd_addr_i,
  input  logic [7:0]  cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [2:0]  rsp_addr_o,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_err_o,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I,
  input  logic        STALL_I
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, RSP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [2:0]  rsp_addr_q, rsp_addr_d;
  logic        rsp_err_q, rsp_err_d;
  // Holds off cmd_ready_o for the first cycle after reset is released.
  logic        live_q;

  logic        xfer_done;
  logic        abort;
  logic        timeout_hit;
  logic        unused_dat;

  assign timeout_hit = (cnt_q == CNT_LAST);
  assign unused_dat  = ^DAT_I[31:11];

  assign ADR_O       = BASE_ADR;
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      addr_q     <= 3'd0;
      data_q     <= 8'd0;
      cnt_q      <= 16'd0;
      rsp_data_q <= 8'd0;
      rsp_addr_q <= 3'd0;
      rsp_err_q  <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_err_q  <= rsp_err_d;
      live_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    xfer_done   = 1'b0;
    abort       = 1'b0;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    CYC_O       = 1'b0;
    STB_O       = 1'b0;
    WE_O        = 1'b0;
    SEL_O       = 4'h0;
    DAT_O       = 32'h0;

    case (state_q)
      IDLE: begin
        cmd_ready_o = live_q;
        cnt_d       = 16'd0;
        if (cmd_valid_i && live_q) begin
          op_d       = cmd_op_i;
          addr_d     = cmd_addr_i;
          data_d     = cmd_data_i;
          rsp_data_d = 8'd0;
          rsp_addr_d = 3'd0;
          rsp_err_d  = 1'b0;
          case (cmd_op_i)
            2'b00, 2'b10: state_d = WR_REQ;
            2'b01:        state_d = RD_REQ;
            default: begin
              state_d   = RSP;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      WR_REQ, RD_REQ: begin
        CYC_O = 1'b1;
        STB_O = 1'b1;
        SEL_O = 4'hF;
        cnt_d = cnt_q + 16'd1;
        if (state_q == WR_REQ) begin
          WE_O  = 1'b1;
          DAT_O = {21'h0, data_q, addr_q};
        end
        // An ack on the accepting edge completes the transfer without a WAIT cycle.
        xfer_done = !STALL_I && ACK_I;
        abort     = !xfer_done && timeout_hit;
        if (!xfer_done && !abort && !STALL_I) begin
          state_d = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
        end
      end
      WR_WAIT, RD_WAIT: begin
        CYC_O     = 1'b1;
        SEL_O     = 4'hF;
        WE_O      = (state_q == WR_WAIT);
        cnt_d     = cnt_q + 16'd1;
        xfer_done = ACK_I;
        abort     = !ACK_I && timeout_hit;
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (xfer_done) begin
      if (state_q == WR_REQ || state_q == WR_WAIT) begin
        if (op_q == 2'b10) begin
          state_d = RD_REQ;
          cnt_d   = 16'd0;
        end else begin
          state_d    = RSP;
          rsp_data_d = 8'd0;
          rsp_addr_d = addr_q;
        end
      end else begin
        state_d    = RSP;
        rsp_data_d = DAT_I[10:3];
        rsp_addr_d = DAT_I[2:0];
      end
    end else if (abort) begin
      state_d    = RSP;
      rsp_err_d  = 1'b1;
      rsp_data_d = 8'd0;
      rsp_addr_d = 3'd0;
    end
  end

endmodule

// File: tb/tb_jtag_wb_master.sv
// Self-checking bench for jtag_wb_master: a procedural Wishbone responder plus a
// command-level reference model of the expected responses and bus transfers.
module tb_jtag_wb_master;

  localparam int          TO   = 20;
  localparam logic [31:0] BASE = 32'h8000_0100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [2:0]  cmd_addr_i;
  logic [7:0]  cmd_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [2:0]  rsp_addr_o;
  logic [7:0]  rsp_data_o;
  logic        rsp_err_o;
  logic        CYC_O, STB_O, WE_O;
  logic [3:0]  SEL_O;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic        ACK_I, STALL_I;

  always #5 clk_i = ~clk_i;

  jtag_wb_master #(.TIMEOUT(TO), .BASE_ADR(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_addr_o(rsp_addr_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .SEL_O(SEL_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
    .ACK_I(ACK_I), .STALL_I(STALL_I)
  );

  int errors = 0;
  int checks = 0;

  // Observations gathered by the stimulus tasks, judged by each test task.
  bit          obs_hs, obs_done, obs_stb_first, obs_gap, obs_we_any, obs_ack_prev;
  int          obs_nstb, obs_cyc;
  logic        obs_we  [2];
  logic [31:0] obs_dat [2];
  logic [3:0]  obs_sel [2];
  logic [31:0] obs_adr [2];
  bit          obs_stable, obs_after_valid, obs_after_ready, obs_idle_bus;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
    logic [2:0] addr;
    logic [1:0] nstb;
    logic       timeout;
  } exp_t;

  // Expected outcome of one command, derived from the command-level rules.
  function automatic exp_t ref_model(input logic [1:0] op, input logic [2:0] a,
                                     input logic [31:0] rd, input bit ack_en);
    exp_t e;
    e = '0;
    if (op == 2'd3) begin
      e.err = 1'b1;
    end else if (!ack_en) begin
      e.err = 1'b1; e.nstb = 2'd1; e.timeout = 1'b1;
    end else if (op == 2'd0) begin
      e.addr = a; e.nstb = 2'd1;
    end else begin
      e.data = 8'((rd >> 3) & 32'hFF);
      e.addr = 3'(rd % 8);
      e.nstb = (op == 2'd2) ? 2'd2 : 2'd1;
    end
    return e;
  endfunction

  function automatic logic [31:0] wr_word(input logic [7:0] d, input logic [2:0] a);
    return 32'(d) * 32'd8 + 32'(a);
  endfunction

  // Issues one command and plays the responder until the response appears.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d,
                         input int stall_n, input int ack_dly, input logic [31:0] rd,
                         input bit ack_en);
    int stall_left, ack_left;
    bit pending, ack_prev;
    obs_hs = 0; obs_done = 0; obs_stb_first = 0; obs_gap = 0; obs_we_any = 0;
    obs_ack_prev = 0; obs_nstb = 0; obs_cyc = 0;
    for (int k = 0; k < 2; k++) begin
      obs_we[k] = 0; obs_dat[k] = 0; obs_sel[k] = 0; obs_adr[k] = 0;
    end
    stall_left = stall_n; ack_left = 0; pending = 0; ack_prev = 0;
    cmd_valid_i = 1; cmd_op_i = op; cmd_addr_i = a; cmd_data_i = d;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready_o) begin obs_hs = 1; break; end
      @(negedge clk_i);
    end
    if (!obs_hs) begin cmd_valid_i = 0; return; end
    @(negedge clk_i);
    cmd_valid_i = 0;
    obs_stb_first = STB_O;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(negedge clk_i);
      if (rsp_valid_o) begin obs_done = 1; obs_ack_prev = ack_prev; break; end
      if (CYC_O) obs_cyc++;
      else if (obs_cyc > 0) obs_gap = 1;
      if (WE_O) obs_we_any = 1;
      STALL_I = 0; ACK_I = 0; DAT_I = $urandom;
      if (STB_O) begin
        if (stall_left > 0) begin
          STALL_I = 1; stall_left--;
        end else begin
          if (obs_nstb < 2) begin
            obs_we[obs_nstb] = WE_O; obs_dat[obs_nstb] = DAT_O;
            obs_sel[obs_nstb] = SEL_O; obs_adr[obs_nstb] = ADR_O;
          end
          obs_nstb++; pending = 1; ack_left = ack_dly; stall_left = stall_n;
        end
      end
      if (pending && ack_en) begin
        if (ack_left == 0) begin ACK_I = 1; DAT_I = rd; pending = 0; end
        else ack_left--;
      end
      ack_prev = ACK_I;
    end
    STALL_I = 0; ACK_I = 0;
    $display("cmd op=%0d addr=%0d data=%02h -> done=%0b err=%0b rdata=%02h raddr=%0d strobes=%0d",
             op, a, d, obs_done, rsp_err_o, rsp_data_o, rsp_addr_o, obs_nstb);
  endtask

  // Holds the response for a while (optionally with a stray ack), then consumes it.
  task automatic finish_rsp(input int hold, input bit stray);
    logic [2:0] a0; logic [7:0] d0; logic e0;
    obs_stable = 1; obs_idle_bus = 0;
    a0 = rsp_addr_o; d0 = rsp_data_o; e0 = rsp_err_o;
    rsp_ready_i = 0;
    for (int i = 0; i < hold; i++) begin
      ACK_I = stray && (i == 0);
      @(negedge clk_i);
      ACK_I = 0;
      if (!rsp_valid_o || rsp_addr_o !== a0 || rsp_data_o !== d0 || rsp_err_o !== e0)
        obs_stable = 0;
    end
    rsp_ready_i = 1;
    @(negedge clk_i);
    rsp_ready_i = 0;
    obs_after_valid = rsp_valid_o;
    obs_after_ready = cmd_ready_o;
    if (stray) begin
      ACK_I = 1;
      @(negedge clk_i);
      ACK_I = 0;
      obs_idle_bus = CYC_O | STB_O | rsp_valid_o;
      obs_after_ready = obs_after_ready & cmd_ready_o;
    end
  endtask

  task automatic test_reset();
    rst_i = 1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({CYC_O, STB_O, WE_O, SEL_O, DAT_O, cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o, rsp_addr_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b sel=%h dat=%h rdy=%b rv=%b err=%b rd=%h ra=%h, expected all 0",
               CYC_O, STB_O, WE_O, SEL_O, DAT_O, cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o, rsp_addr_o);
    end
    rst_i = 0;
    #1;
    checks++;
    if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b expected 0", cmd_ready_o); end
    @(negedge clk_i);
    checks++;
    if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b expected 1", cmd_ready_o); end
  endtask

  task automatic test_write();
    run_cmd(2'd0, 3'd5, 8'hA5, 0, 8, $urandom, 1'b1);
    checks++;
    if (!obs_done) begin errors++; $display("FAIL write_done: got no response, expected one"); end
    checks++;
    if (obs_stb_first !== 1'b1) begin errors++; $display("FAIL write_stb_latency: got %b expected 1", obs_stb_first); end
    checks++;
    if (obs_nstb != 1) begin errors++; $display("FAIL write_nstb: got %0d expected 1", obs_nstb); end
    checks++;
    if ({obs_we[0], obs_sel[0], obs_dat[0]} !== {1'b1, 4'hF, 32'h0000052D}) begin
      errors++;
      $display("FAIL write_bus: got we=%b sel=%h dat=%h expected we=1 sel=f dat=0000052d", obs_we[0], obs_sel[0], obs_dat[0]);
    end
    checks++;
    if (obs_adr[0] !== BASE) begin errors++; $display("FAIL write_adr: got %h expected %h", obs_adr[0], BASE); end
    checks++;
    if ({rsp_err_o, rsp_data_o, rsp_addr_o} !== {1'b0, 8'h00, 3'd5}) begin
      errors++;
      $display("FAIL write_rsp: got err=%b data=%h addr=%0d expected err=0 data=00 addr=5", rsp_err_o, rsp_data_o, rsp_addr_o);
    end
    checks++;
    if (obs_ack_prev !== 1'b1) begin errors++; $display("FAIL write_rsp_latency: got ack_prev=%b expected 1", obs_ack_prev); end
    finish_rsp(2, 1'b0);
    checks++;
    if ({obs_after_valid, obs_after_ready} !== 2'b01) begin
      errors++; $display("FAIL write_consume: got valid=%b ready=%b expected valid=0 ready=1", obs_after_valid, obs_after_ready);
    end
  endtask

  task automatic test_read();
    run_cmd(2'd1, 3'($urandom), 8'($urandom), 2, 3, 32'h0000039A, 1'b1);
    checks++;
    if ({rsp_err_o, rsp_data_o, rsp_addr_o} !== {1'b0, 8'h73, 3'd2}) begin
      errors++;
      $display("FAIL read_rsp: got err=%b data=%h addr=%0d expected err=0 data=73 addr=2", rsp_err_o, rsp_data_o, rsp_addr_o);
    end
    checks++;
    if (obs_we_any || obs_nstb != 1 || obs_dat[0] !== 32'h0) begin
      errors++;
      $display("FAIL read_bus: got we_any=%b nstb=%0d dat=%h expected we_any=0 nstb=1 dat=0", obs_we_any, obs_nstb, obs_dat[0]);
    end
    finish_rsp(0, 1'b0);
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    exp_t e;
    rd = $urandom;
    e = ref_model(2'd2, 3'd3, rd, 1'b1);
    run_cmd(2'd2, 3'd3, 8'h11, 7, 4, rd, 1'b1);
    checks++;
    if (obs_nstb != 2 || obs_we[0] !== 1'b1 || obs_we[1] !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_strobes: got nstb=%0d we0=%b we1=%b expected nstb=2 we0=1 we1=0", obs_nstb, obs_we[0], obs_we[1]);
    end
    checks++;
    if (obs_dat[0] !== 32'h0000008B || obs_dat[1] !== 32'h0) begin
      errors++; $display("FAIL wr_rd_dat: got %h/%h expected 0000008b/00000000", obs_dat[0], obs_dat[1]);
    end
    checks++;
    if (obs_gap) begin errors++; $display("FAIL wr_rd_cyc_gap: got gap=1 expected 0"); end
    checks++;
    if ({rsp_err_o, rsp_data_o, rsp_addr_o} !== {e.err, e.data, e.addr}) begin
      errors++;
      $display("FAIL wr_rd_rsp: got err=%b data=%h addr=%0d expected err=%b data=%h addr=%0d",
               rsp_err_o, rsp_data_o, rsp_addr_o, e.err, e.data, e.addr);
    end
    finish_rsp(1, 1'b0);
  endtask

  task automatic test_timeout();
    run_cmd(2'd0, 3'($urandom), 8'($urandom), 0, 0, 32'h0, 1'b0);
    checks++;
    if (obs_cyc != TO) begin errors++; $display("FAIL timeout_cyc_len: got %0d expected %0d", obs_cyc, TO); end
    checks++;
    if ({rsp_err_o, rsp_data_o, rsp_addr_o, obs_ack_prev} !== {1'b1, 8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_rsp: got err=%b data=%h addr=%0d expected err=1 data=00 addr=0", rsp_err_o, rsp_data_o, rsp_addr_o);
    end
    finish_rsp(3, 1'b1);
    checks++;
    if (!obs_stable) begin errors++; $display("FAIL timeout_late_ack: got response changed expected stable"); end
    checks++;
    if ({obs_after_valid, obs_after_ready, obs_idle_bus} !== 3'b010) begin
      errors++;
      $display("FAIL timeout_idle: got valid=%b ready=%b bus=%b expected 0 1 0", obs_after_valid, obs_after_ready, obs_idle_bus);
    end
    run_cmd(2'd2, 3'($urandom), 8'($urandom), 3, 0, 32'h0, 1'b0);
    checks++;
    if (obs_cyc != TO || obs_nstb != 1 || rsp_err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_wr_rd: got cyc=%0d nstb=%0d err=%b expected cyc=%0d nstb=1 err=1", obs_cyc, obs_nstb, rsp_err_o, TO);
    end
    finish_rsp(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit leaked;
    logic [31:0] rd;
    exp_t e;
    cmd_valid_i = 1; cmd_op_i = 2'd1; cmd_addr_i = 3'($urandom); cmd_data_i = 8'($urandom);
    STALL_I = 0; ACK_I = 0;
    @(negedge clk_i);
    cmd_valid_i = 0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({CYC_O, STB_O} !== 2'b10) begin errors++; $display("FAIL rstmid_in_wait: got cyc=%b stb=%b expected 1 0", CYC_O, STB_O); end
    rst_i = 1;
    @(negedge clk_i);
    checks++;
    if ({CYC_O, STB_O, WE_O, SEL_O, DAT_O, rsp_valid_o, cmd_ready_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got cyc=%b stb=%b we=%b sel=%h dat=%h rv=%b rdy=%b expected all 0",
               CYC_O, STB_O, WE_O, SEL_O, DAT_O, rsp_valid_o, cmd_ready_o);
    end
    rst_i = 0;
    ACK_I = 1;
    @(negedge clk_i);
    ACK_I = 0;
    leaked = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid_o || CYC_O) leaked = 1;
      @(negedge clk_i);
    end
    checks++;
    if (leaked || cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_no_rsp: got leaked=%b ready=%b expected 0 1", leaked, cmd_ready_o);
    end
    rd = $urandom;
    e = ref_model(2'd1, 3'd0, rd, 1'b1);
    run_cmd(2'd1, 3'($urandom), 8'($urandom), 1, 2, rd, 1'b1);
    checks++;
    if ({rsp_err_o, rsp_data_o, rsp_addr_o} !== {e.err, e.data, e.addr}) begin
      errors++;
      $display("FAIL rstmid_next_cmd: got err=%b data=%h addr=%0d expected err=%b data=%h addr=%0d",
               rsp_err_o, rsp_data_o, rsp_addr_o, e.err, e.data, e.addr);
    end
    finish_rsp(0, 1'b0);
  endtask

  task automatic test_reserved();
    run_cmd(2'd3, 3'($urandom), 8'($urandom), 0, 0, 32'h0, 1'b1);
    checks++;
    if (obs_cyc != 0 || obs_nstb != 0 || obs_stb_first !== 1'b0) begin
      errors++; $display("FAIL reserved_bus: got cyc=%0d nstb=%0d expected 0 0", obs_cyc, obs_nstb);
    end
    checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_data_o, rsp_addr_o, cmd_ready_o} !== {1'b1, 1'b1, 8'h00, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reserved_rsp: got valid=%b err=%b data=%h addr=%0d ready=%b expected 1 1 00 0 0",
               rsp_valid_o, rsp_err_o, rsp_data_o, rsp_addr_o, cmd_ready_o);
    end
    finish_rsp(5, 1'b0);
    checks++;
    if (!obs_stable) begin errors++; $display("FAIL reserved_hold: got response changed expected stable for 5 cycles"); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 3'($urandom);
      run_cmd(2'd0, a, 8'($urandom), 0, 0, 32'h0, 1'b1);
      checks++;
      if (!obs_hs || !obs_done || {rsp_err_o, rsp_addr_o} !== {1'b0, a} || obs_nstb != 1) begin
        errors++;
        $display("FAIL b2b_%0d: got hs=%b done=%b err=%b addr=%0d nstb=%0d expected 1 1 0 %0d 1",
                 i, obs_hs, obs_done, rsp_err_o, rsp_addr_o, obs_nstb, a);
      end
      finish_rsp(0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [1:0] op; logic [2:0] a; logic [7:0] d; logic [31:0] rd; bit ack_en;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom); a = 3'($urandom); d = 8'($urandom); rd = $urandom;
      ack_en = ($urandom_range(5, 0) != 0);
      e = ref_model(op, a, rd, ack_en);
      run_cmd(op, a, d, $urandom_range(4, 0), $urandom_range(8, 0), rd, ack_en);
      checks++;
      if (!obs_done || {rsp_err_o, rsp_data_o, rsp_addr_o} !== {e.err, e.data, e.addr}) begin
        errors++;
        $display("FAIL rand_rsp_%0d: got done=%b err=%b data=%h addr=%0d expected err=%b data=%h addr=%0d",
                 i, obs_done, rsp_err_o, rsp_data_o, rsp_addr_o, e.err, e.data, e.addr);
      end
      checks++;
      if (obs_nstb != int'(e.nstb) || obs_gap || obs_ack_prev !== (e.nstb != 0 && !e.timeout)) begin
        errors++;
        $display("FAIL rand_bus_%0d: got nstb=%0d gap=%b ack_prev=%b expected nstb=%0d gap=0 ack_prev=%b",
                 i, obs_nstb, obs_gap, obs_ack_prev, e.nstb, (e.nstb != 0 && !e.timeout));
      end
      if (e.nstb != 0) begin
        checks++;
        if (obs_we[0] !== (op != 2'd1) || obs_dat[0] !== ((op == 2'd1) ? 32'h0 : wr_word(d, a))) begin
          errors++;
          $display("FAIL rand_strobe_%0d: got we=%b dat=%h expected we=%b dat=%h",
                   i, obs_we[0], obs_dat[0], (op != 2'd1), (op == 2'd1) ? 32'h0 : wr_word(d, a));
        end
      end
      if (e.timeout) begin
        checks++;
        if (obs_cyc != TO) begin errors++; $display("FAIL rand_timeout_%0d: got cyc=%0d expected %0d", i, obs_cyc, TO); end
      end
      finish_rsp($urandom_range(3, 0), 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1; cmd_valid_i = 0; cmd_op_i = 0; cmd_addr_i = 0; cmd_data_i = 0;
    rsp_ready_i = 0; DAT_I = 0; ACK_I = 0; STALL_I = 0;
    test_reset();
    test_write();
    test_read();
    test_write_read();
    test_timeout();
    test_reset_mid();
    test_reserved();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
